// File: rtl/ddr5_pwrgd_fail_seq.sv
// rtl/ddr5_pwrgd_fail_seq.sv - per-channel DDR5 DRAM power-good qualification, fault latch and DIMM reset sequencer
module ddr5_pwrgd_fail_seq #(
  parameter int unsigned MC_SIZE      = 4,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned RST_DLY_CYC  = 32,
  parameter bit          INTR_GATE    = 1'b1
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iFM_INTR_PRSNT,
  input  logic               iINTR_SKU,
  input  logic               iPWRGD_PS_PWROK,
  input  logic [MC_SIZE-1:0] iPWRGD_DRAMPWRGD_DDRIO,
  input  logic [MC_SIZE-1:0] iMC_RST_N,
  input  logic [MC_SIZE-1:0] iADR_LOGIC,
  input  logic               iFLT_CLR,
  inout  wire  [MC_SIZE-1:0] ioPWRGD_FAIL_CH_DIMM_CPU,
  output logic [MC_SIZE-1:0] oDIMM_MEM_FLT,
  output logic [MC_SIZE-1:0] oPWRGD_DRAMPWRGD_OK,
  output logic [MC_SIZE-1:0] oFPGA_DIMM_RST_N,
  output logic               oFLT_ANY
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_ON       = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYC - 1);
  localparam logic [15:0] RST_DLY  = 16'(RST_DLY_CYC);

  // An interposer with the CLX SKU keeps every channel powered off.
  logic en;
  assign en = iPWRGD_PS_PWROK & ~(INTR_GATE & iFM_INTR_PRSNT & iINTR_SKU);

  for (genvar i = 0; i < MC_SIZE; i++) begin : g_ch
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ok_q, ok_d;
    logic        flt_q, flt_d;
    logic        rst_q, rst_d;
    logic        pg;

    assign pg = iPWRGD_DRAMPWRGD_DDRIO[i];

    // Next-state, counter and registered-output decode for this channel.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_OFF: begin
          cnt_d = '0;
          if (en && pg) begin
            state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!en || !pg) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_ON: begin
          // Losing EN takes priority over a simultaneous DRAMPWRGD drop: no fault.
          if (!en) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else if (!pg) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
          end else if (ok_q && (cnt_q != RST_DLY)) begin
            // Counts cycles since OK went high, saturating at the reset delay.
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_FAULT: begin
          cnt_d = '0;
          if (iFLT_CLR) begin
            state_d = ST_OFF;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase

      ok_d  = (state_q == ST_ON) && (state_d == ST_ON);
      flt_d = (state_d == ST_FAULT);
      rst_d = ok_d && (cnt_q == RST_DLY) && iMC_RST_N[i];
    end

    // Channel state, counter and output registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        ok_q    <= 1'b0;
        flt_q   <= 1'b0;
        rst_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ok_q    <= ok_d;
        flt_q   <= flt_d;
        rst_q   <= rst_d;
      end
    end

    assign oPWRGD_DRAMPWRGD_OK[i] = ok_q;
    assign oDIMM_MEM_FLT[i]       = flt_q;
    assign oFPGA_DIMM_RST_N[i]    = rst_q;
    // Open drain: pull low while the channel is not good, unless ADR owns the line.
    assign ioPWRGD_FAIL_CH_DIMM_CPU[i] = (ok_q || iADR_LOGIC[i]) ? 1'bz : 1'b0;
  end

  // Summary fault flag, one cycle behind the per-channel latches.
  logic flt_any_q;
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      flt_any_q <= 1'b0;
    end else begin
      flt_any_q <= |oDIMM_MEM_FLT;
    end
  end
  assign oFLT_ANY = flt_any_q;

endmodule

// File: tb/tb_ddr5_pwrgd_fail_seq.sv
// tb/tb_ddr5_pwrgd_fail_seq.sv - scoreboard bench for ddr5_pwrgd_fail_seq
module tb_ddr5_pwrgd_fail_seq;

  localparam int K_OK  = 0;
  localparam int K_FLT = 1;
  localparam int K_RST = 2;
  localparam int K_ANY = 3;
  localparam int K_PF  = 4;

  logic       clk;
  logic       rst_n;
  logic       intr_prsnt;
  logic       intr_sku;
  logic       pwrok;
  logic [3:0] pg;
  logic [3:0] mc_rst_n;
  logic [3:0] adr;
  logic       flt_clr;
  wire  [3:0] pwrgd_fail;
  logic [3:0] mem_flt;
  logic [3:0] dram_ok;
  logic [3:0] dimm_rst_n;
  logic       flt_any;

  pullup pu0 (pwrgd_fail[0]);
  pullup pu1 (pwrgd_fail[1]);
  pullup pu2 (pwrgd_fail[2]);
  pullup pu3 (pwrgd_fail[3]);

  ddr5_pwrgd_fail_seq #(
    .MC_SIZE     (4),
    .DEBOUNCE_CYC(16),
    .RST_DLY_CYC (32),
    .INTR_GATE   (1'b1)
  ) dut (
    .iClk                    (clk),
    .iRst_n                  (rst_n),
    .iFM_INTR_PRSNT          (intr_prsnt),
    .iINTR_SKU               (intr_sku),
    .iPWRGD_PS_PWROK         (pwrok),
    .iPWRGD_DRAMPWRGD_DDRIO  (pg),
    .iMC_RST_N               (mc_rst_n),
    .iADR_LOGIC              (adr),
    .iFLT_CLR                (flt_clr),
    .ioPWRGD_FAIL_CH_DIMM_CPU(pwrgd_fail),
    .oDIMM_MEM_FLT           (mem_flt),
    .oPWRGD_DRAMPWRGD_OK     (dram_ok),
    .oFPGA_DIMM_RST_N        (dimm_rst_n),
    .oFLT_ANY                (flt_any)
  );

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   passed  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] sample(input int kind);
    case (kind)
      K_OK:    return dram_ok;
      K_FLT:   return mem_flt;
      K_RST:   return dimm_rst_n;
      K_ANY:   return {3'b000, flt_any};
      default: return pwrgd_fail;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    logic [3:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        act = sample(q[i].kind);
        checks = checks + 1;
        if (act === q[i].exp) begin
          passed = passed + 1;
        end else begin
          $display("FAIL %s cyc=%0d got=%b expected=%b", q[i].name, cyc, act, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  task automatic push(input int d, input int kind, input logic [3:0] e, input string n);
    exp_t x;
    x.cyc  = cyc + d;
    x.kind = kind;
    x.exp  = e;
    x.name = n;
    q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    intr_prsnt = 1'b0;
    intr_sku   = 1'b0;
    pwrok      = 1'b0;
    pg         = 4'b0000;
    mc_rst_n   = 4'b1000;
    adr        = 4'b0000;
    flt_clr    = 1'b0;

    step(3);
    checks = checks + 1;
    if (dram_ok === 4'b0000) passed = passed + 1;
    else $display("FAIL direct_reset_ok got=%b", dram_ok);
    checks = checks + 1;
    if (mem_flt === 4'b0000) passed = passed + 1;
    else $display("FAIL direct_reset_flt got=%b", mem_flt);
    checks = checks + 1;
    if (dimm_rst_n === 4'b0000) passed = passed + 1;
    else $display("FAIL direct_reset_dimm_rst got=%b", dimm_rst_n);
    checks = checks + 1;
    if (flt_any === 1'b0) passed = passed + 1;
    else $display("FAIL direct_reset_flt_any got=%b", flt_any);
    push(0, K_OK,  4'b0000, "reset_ok");
    push(0, K_FLT, 4'b0000, "reset_flt");
    push(0, K_RST, 4'b0000, "reset_dimm_rst");
    push(0, K_ANY, 4'b0000, "reset_flt_any");
    push(0, K_PF,  4'b0000, "reset_pwrgd_fail");
    rst_n = 1'b1;
    step(2);

    // Channel 0 debounce: OK and Z on PWRGD_FAIL 17 cycles after the first sampled rise.
    pwrok = 1'b1;
    pg    = 4'b0001;
    push(17, K_OK, 4'b0000, "ch0_ok_early");
    push(18, K_OK, 4'b0001, "ch0_ok_rise");
    push(17, K_PF, 4'b0000, "ch0_pf_driven");
    push(18, K_PF, 4'b0001, "ch0_pf_release");
    step(20);

    // Channel 1 glitch at debounce cycle 10 restarts the count.
    pg = 4'b0011;
    push(18, K_OK, 4'b0001, "ch1_glitch_no_ok");
    push(28, K_OK, 4'b0001, "ch1_restart_early");
    push(29, K_OK, 4'b0011, "ch1_restart_ok");
    step(10);
    pg = 4'b0001;
    step(1);
    pg = 4'b0011;
    step(20);

    // Channels 2 and 3 come up; channel 3 DIMM reset releases 33 cycles after OK.
    pg = 4'b1111;
    push(17, K_OK,  4'b0011, "ch23_ok_early");
    push(18, K_OK,  4'b1111, "ch23_ok_rise");
    push(50, K_RST, 4'b0000, "ch3_rst_early");
    push(51, K_RST, 4'b1000, "ch3_rst_release");
    step(53);
    mc_rst_n = 4'b0000;
    push(1, K_RST, 4'b0000, "ch3_mc_rst_assert");
    step(2);
    mc_rst_n = 4'b1000;
    push(0, K_RST, 4'b0000, "ch3_mc_rst_hold");
    push(1, K_RST, 4'b1000, "ch3_mc_rst_release");
    step(2);

    // Channel 2 faults; clear it while channel 1 faults in the same cycle.
    pg = 4'b1011;
    push(0, K_FLT, 4'b0000, "ch2_flt_before");
    push(1, K_FLT, 4'b0100, "ch2_flt_set");
    push(1, K_OK,  4'b1011, "ch2_flt_others_ok");
    push(1, K_RST, 4'b1000, "ch2_flt_ch3_rst");
    push(1, K_PF,  4'b1011, "ch2_flt_pf");
    push(1, K_ANY, 4'b0000, "ch2_any_lag");
    push(2, K_ANY, 4'b0001, "ch2_any_set");
    step(3);
    flt_clr = 1'b1;
    pg      = 4'b1001;
    push(1, K_FLT, 4'b0010, "clr_and_new_fault");
    push(1, K_OK,  4'b1001, "ch1_fault_ok");
    push(2, K_ANY, 4'b0001, "any_held");
    step(1);
    flt_clr = 1'b0;
    step(2);
    flt_clr = 1'b1;
    push(1, K_FLT, 4'b0000, "ch1_flt_clear");
    push(2, K_ANY, 4'b0000, "any_clear");
    step(1);
    flt_clr = 1'b0;
    step(2);

    // PWROK and DRAMPWRGD[0] fall together: OFF without fault.
    pwrok = 1'b0;
    pg    = 4'b1000;
    push(1, K_FLT, 4'b0000, "pwrok_drop_no_flt");
    push(1, K_OK,  4'b0000, "pwrok_drop_ok");
    push(1, K_RST, 4'b0000, "pwrok_drop_rst");
    push(2, K_ANY, 4'b0000, "pwrok_drop_any");
    step(2);
    pwrok = 1'b1;
    pg    = 4'b1111;
    push(17, K_OK, 4'b0000, "all_ok_early");
    push(18, K_OK, 4'b1111, "all_ok_rise");
    step(20);

    // CLX interposer forces every channel OFF.
    intr_prsnt = 1'b1;
    intr_sku   = 1'b1;
    push(0, K_OK,  4'b1111, "intr_before");
    push(1, K_OK,  4'b0000, "intr_ok_off");
    push(1, K_FLT, 4'b0000, "intr_no_flt");
    push(1, K_PF,  4'b0000, "intr_pf_driven");
    push(2, K_ANY, 4'b0000, "intr_no_any");
    step(2);

    // ADR releases PWRGD_FAIL while OFF.
    adr = 4'b1000;
    push(0, K_PF, 4'b1000, "adr_ch3_z");
    step(1);
    adr = 4'b0000;
    push(0, K_PF, 4'b0000, "adr_off_driven");
    step(1);

    // Asynchronous reset in ON, then a full restart.
    intr_prsnt = 1'b0;
    push(18, K_OK, 4'b1111, "pre_reset_ok");
    step(20);
    rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if (dram_ok === 4'b0000) passed = passed + 1;
    else $display("FAIL direct_async_reset_ok got=%b", dram_ok);
    push(0, K_OK, 4'b0000, "async_reset_ok");
    push(0, K_PF, 4'b0000, "async_reset_pf");
    step(2);
    rst_n = 1'b1;
    push(17, K_OK, 4'b0000, "restart_ok_early");
    push(18, K_OK, 4'b1111, "restart_ok_rise");
    step(22);

    foreach (q[i]) begin
      checks = checks + 1;
      $display("FAIL %s never sampled (due cyc=%0d, now %0d)", q[i].name, q[i].cyc, cyc);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ddr5_pwrgd_fail_seq.md
DDR5_PWRGD_FAIL_SEQ -- requirements
Module: ddr5_pwrgd_fail_seq

Interface
REQ-001 Parameter MC_SIZE, default 4: number of independent memory-controller channels, range 1-16.
REQ-002 Parameter DEBOUNCE_CYC, default 16: cycles DRAMPWRGD must stay stable high before a channel is declared good, range 1-65535.
REQ-003 Parameter RST_DLY_CYC, default 32: cycles from channel-good to DIMM reset release eligibility, range 0-65535.
REQ-004 Parameter INTR_GATE, default 1: when 1, interposer present with CLX SKU forces all channels to OFF.
REQ-005 iClk  in  1  system clock; all logic is single clock domain.
REQ-006 iRst_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to iClk.
REQ-007 iFM_INTR_PRSNT  in  1  interposer present.
REQ-008 iINTR_SKU  in  1  interposer SKU: 1 = CLX, 0 = BRS.
REQ-009 iPWRGD_PS_PWROK  in  1  power-supply PWROK, common to all channels.
REQ-010 iPWRGD_DRAMPWRGD_DDRIO  in  MC_SIZE  per-channel MC VR power good, synchronous.
REQ-011 iMC_RST_N  in  MC_SIZE  per-channel reset request from the memory controller.
REQ-012 iADR_LOGIC  in  MC_SIZE  per-channel ADR override.
REQ-013 iFLT_CLR  in  1  single-cycle pulse that clears all latched faults.
REQ-014 ioPWRGD_FAIL_CH_DIMM_CPU  inout  MC_SIZE  open-drain PWRGD_FAIL; the block drives only 0 or Z.
REQ-015 oDIMM_MEM_FLT  out  MC_SIZE  latched per-channel memory fault.
REQ-016 oPWRGD_DRAMPWRGD_OK  out  MC_SIZE  channel power good, qualified.
REQ-017 oFPGA_DIMM_RST_N  out  MC_SIZE  reset to the DIMMs.
REQ-018 oFLT_ANY  out  1  OR of oDIMM_MEM_FLT.

Function
REQ-019 Each channel shall run its own FSM with states OFF, DEBOUNCE, ON, FAULT, plus its own 16-bit counter.
REQ-020 Common enable EN = iPWRGD_PS_PWROK AND NOT (INTR_GATE AND iFM_INTR_PRSNT AND iINTR_SKU).
REQ-021 OFF -> DEBOUNCE when EN=1 and DRAMPWRGD=1; the counter loads 0 on entry.
REQ-022 DEBOUNCE: the counter increments each cycle while DRAMPWRGD=1; a 0 on DRAMPWRGD returns the FSM to OFF; reaching DEBOUNCE_CYC-1 moves it to ON; EN=0 moves it to OFF.
REQ-023 ON: entry clears the counter, which then counts saturating at RST_DLY_CYC.
REQ-024 ON -> FAULT when DRAMPWRGD falls while EN=1.
REQ-025 ON -> OFF with no fault when EN falls. If EN and DRAMPWRGD fall in the same cycle, OFF wins (no fault).
REQ-026 FAULT sets oDIMM_MEM_FLT[i]=1, which stays latched.
REQ-027 FAULT -> OFF only on iFLT_CLR=1.
REQ-028 If iFLT_CLR and a new fault occur in the same cycle, the fault wins.
REQ-029 oPWRGD_DRAMPWRGD_OK[i]=1 only in ON, registered, so it asserts the cycle after entering ON.
REQ-030 ioPWRGD_FAIL[i] shall be driven 0 when the state is not ON and iADR_LOGIC[i]=0; otherwise it is Z.
REQ-031 iADR_LOGIC[i]=1 forces Z in every state and does not alter the FSM.
REQ-032 oFPGA_DIMM_RST_N[i] = 1 only when the state is ON, the counter has reached RST_DLY_CYC, and iMC_RST_N[i]=1; otherwise 0. It is registered.
REQ-033 With RST_DLY_CYC=0, oFPGA_DIMM_RST_N follows iMC_RST_N from the first ON cycle.
REQ-034 oFLT_ANY is registered, one cycle after oDIMM_MEM_FLT.
REQ-035 Channels shall be fully independent: a fault on one channel shall not change another channel's state.

Reset
REQ-036 On iRst_n=0, all FSMs go to OFF and all counters to 0.
REQ-037 Reset values: oDIMM_MEM_FLT=0, oPWRGD_DRAMPWRGD_OK=0, oFPGA_DIMM_RST_N=0, oFLT_ANY=0, ioPWRGD_FAIL=0 (Z if ADR=1).
REQ-038 Reset clears latched faults.
REQ-039 Reset mid-DEBOUNCE or mid-ON aborts immediately, asynchronously.

Verification
REQ-040 MC_SIZE=4, DEBOUNCE_CYC=16: PWROK=1, DRAMPWRGD[0] rises -> OK[0]=1 exactly 17 cycles later; PWRGD_FAIL[0] goes Z the same cycle.
REQ-041 DRAMPWRGD[1] glitches low at debounce cycle 10 -> OK[1] stays 0; the 16-cycle count restarts from the next rise.
REQ-042 Channel 2 in ON, DRAMPWRGD[2] drops with PWROK=1 -> MEM_FLT[2]=1 next cycle, FLT_ANY=1 one cycle after; channels 0, 1 and 3 are unchanged; iFLT_CLR returns channel 2 to OFF.
REQ-043 PWROK and DRAMPWRGD[0] fall in the same cycle -> MEM_FLT[0]=0, OK[0]=0.
REQ-044 RST_DLY_CYC=32, iMC_RST_N[3]=1 -> DIMM_RST_N[3]=1 33 cycles after OK[3]; ADR[3]=1 while OFF -> PWRGD_FAIL[3]=Z.
REQ-045 INTR_PRSNT=1 with SKU=1 while all channels are ON -> all channels go OFF the next cycle, with no faults.
